// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 operand classifier.
//   FCLASS_W      width of the one-hot class mask (RISC-V fclass order)
//   FC_*          bit index of each class inside the mask
//   HALF/SINGLE/DOUBLE  binary format presets (exponent width, fraction width)
//   fp_flags_t    field flags decoded from an operand ahead of classification
package fp_pkg;

   localparam int FCLASS_W = 10;

   localparam int FC_NINF  = 0;
   localparam int FC_NNORM = 1;
   localparam int FC_NSUB  = 2;
   localparam int FC_NZERO = 3;
   localparam int FC_PZERO = 4;
   localparam int FC_PSUB  = 5;
   localparam int FC_PNORM = 6;
   localparam int FC_PINF  = 7;
   localparam int FC_SNAN  = 8;
   localparam int FC_QNAN  = 9;

   typedef struct packed {
      int unsigned exp_w;
      int unsigned man_w;
   } fp_fmt_t;

   localparam fp_fmt_t HALF   = '{exp_w: 5,  man_w: 10};
   localparam fp_fmt_t SINGLE = '{exp_w: 8,  man_w: 23};
   localparam fp_fmt_t DOUBLE = '{exp_w: 11, man_w: 52};

   typedef logic [FCLASS_W-1:0] fclass_t;

   typedef struct packed {
      logic sign;       // operand sign bit
      logic exp_ones;   // exponent field all ones
      logic exp_zeros;  // exponent field all zeros
      logic sig_zeros;  // fraction field all zeros
      logic quiet;      // fraction MSB
   } fp_flags_t;

endpackage

// File: rtl/fp_class_decode.sv
// Combinational classifier: field flags -> one-hot fclass mask.
//   flags_i  decoded sign/exponent/fraction flags of one operand
//   class_o  one-hot class mask, sign resolved, sign ignored for NaN
module fp_class_decode
   import fp_pkg::*;
#(
   parameter int EXP_W = HALF.exp_w,
   parameter int MAN_W = HALF.man_w
) (
   input  fp_flags_t flags_i,
   output fclass_t   class_o
);

   // A format needs at least two exponent bits and one fraction bit to
   // distinguish inf/NaN/subnormal; anything smaller produces no class.
   localparam bit FMT_OK = (EXP_W >= 2) && (MAN_W >= 1);

   // NOTE: every output of a combinational block gets a default first so no
   // path through the if/else chain leaves it unassigned (no inferred latch).
   always_comb begin
      class_o = '0;
      if (FMT_OK) begin
         if (flags_i.exp_ones && !flags_i.sig_zeros) begin
            class_o[flags_i.quiet ? FC_QNAN : FC_SNAN] = 1'b1;
         end else if (flags_i.exp_ones) begin
            class_o[flags_i.sign ? FC_NINF : FC_PINF] = 1'b1;
         end else if (flags_i.exp_zeros && flags_i.sig_zeros) begin
            class_o[flags_i.sign ? FC_NZERO : FC_PZERO] = 1'b1;
         end else if (flags_i.exp_zeros) begin
            class_o[flags_i.sign ? FC_NSUB : FC_PSUB] = 1'b1;
         end else begin
            class_o[flags_i.sign ? FC_NNORM : FC_PNORM] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_classify_pipe.sv
// Two-stage pipelined IEEE-754 operand classifier with valid/ready handshakes,
// tag pass-through, saturating per-class counters and a sticky sNaN flag.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_data operand, in_tag user tag
//   out_valid/out_ready   output handshake; out_data/out_tag passed through,
//                         out_class one-hot fclass mask
//   cnt_sel/cnt_value     combinational read of one class counter (10-15 -> 0)
//   cnt_clr               clears all counters and snan_seen
//   snan_seen             sticky: an sNaN result has transferred
module fp_classify_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = HALF.exp_w,
   parameter int MAN_W = HALF.man_w,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     in_data,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic [FCLASS_W-1:0]      out_class,
   input  logic [3:0]               cnt_sel,
   output logic [CNT_W-1:0]         cnt_value,
   input  logic                     cnt_clr,
   output logic                     snan_seen
);

   localparam int N = 1 + EXP_W + MAN_W;

   // ---------------- handshake ----------------
   logic stall, advance, out_xfer;

   // Both stages move together; a stalled output freezes the whole pipe so
   // no bubble is ever collapsed.
   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = advance;
   assign out_xfer = out_valid & out_ready;

   // ---------------- field flags ----------------
   logic [EXP_W-1:0] in_exp;
   logic [MAN_W-1:0] in_frac;
   fp_flags_t        in_flags;

   assign in_exp   = in_data[N-2 -: EXP_W];
   assign in_frac  = in_data[MAN_W-1:0];
   assign in_flags = '{sign:      in_data[N-1],
                       exp_ones:  &in_exp,
                       exp_zeros: ~|in_exp,
                       sig_zeros: ~|in_frac,
                       quiet:     in_frac[MAN_W-1]};

   // ---------------- pipeline registers ----------------
   logic             s1_valid_q, s1_valid_d;
   logic [N-1:0]     s1_data_q,  s1_data_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   fp_flags_t        s1_flags_q, s1_flags_d;
   fclass_t          s1_class;

   logic             s2_valid_q, s2_valid_d;
   logic [N-1:0]     s2_data_q,  s2_data_d;
   logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
   fclass_t          s2_class_q, s2_class_d;

   fp_class_decode #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_decode (
      .flags_i (s1_flags_q),
      .class_o (s1_class)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_tag_d   = s1_tag_q;
      s1_flags_d = s1_flags_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      s2_class_d = s2_class_q;
      if (advance) begin
         // in_valid=0 loads a bubble into S1
         s1_valid_d = in_valid;
         s1_data_d  = in_data;
         s1_tag_d   = in_tag;
         s1_flags_d = in_flags;
         s2_valid_d = s1_valid_q;
         s2_data_d  = s1_data_q;
         s2_tag_d   = s1_tag_q;
         s2_class_d = s1_class;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_tag_q   <= '0;
         s1_flags_q <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
         s2_class_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_tag_q   <= s1_tag_d;
         s1_flags_q <= s1_flags_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
         s2_class_q <= s2_class_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign out_class = s2_class_q;

   // ---------------- statistics ----------------
   logic [CNT_W-1:0] cnt_q [FCLASS_W];
   logic [CNT_W-1:0] cnt_d [FCLASS_W];
   logic             snan_q, snan_d;

   always_comb begin
      cnt_d  = cnt_q;
      snan_d = snan_q;
      if (cnt_clr) begin
         // clear beats a same-cycle increment or sNaN set
         cnt_d  = '{default: '0};
         snan_d = 1'b0;
      end else if (out_xfer) begin
         for (int i = 0; i < FCLASS_W; i++) begin
            if (s2_class_q[i] && (cnt_q[i] != '1)) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         if (s2_class_q[FC_SNAN]) begin
            snan_d = 1'b1;
         end
      end
   end

   // NOTE: the counter bank is architecturally visible, so unlike a plain data
   // memory it is reset explicitly and reads 0 right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '{default: '0};
         snan_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         snan_q <= snan_d;
      end
   end

   always_comb begin
      cnt_value = '0;
      if (cnt_sel < 4'(FCLASS_W)) begin
         cnt_value = cnt_q[cnt_sel];
      end
   end

   assign snan_seen = snan_q;

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Self-checking bench: a half-precision instance (2-bit counters) and a
// single-precision instance share all handshake/control inputs, so both
// pipelines move in lockstep and one scoreboard checks them together.
module tb_fp_classify_pipe;
   import fp_pkg::*;

   localparam int HE = 5;
   localparam int HM = 10;
   localparam int SE = 8;
   localparam int SM = 23;
   localparam int HC_MAX = 3;      // CNT_W=2 on the half instance
   localparam int SC_MAX = 65535;  // CNT_W=16 on the single instance

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, cnt_clr;
   logic [3:0]  in_tag, cnt_sel;
   logic [15:0] in_data_h;
   logic [31:0] in_data_s;

   logic        in_ready_h, out_valid_h, snan_h;
   logic [15:0] out_data_h;
   logic [3:0]  out_tag_h;
   logic [9:0]  out_class_h;
   logic [1:0]  cnt_value_h;

   logic        in_ready_s, out_valid_s, snan_s;
   logic [31:0] out_data_s;
   logic [3:0]  out_tag_s;
   logic [9:0]  out_class_s;
   logic [15:0] cnt_value_s;

   always #5 clk = ~clk;

   fp_classify_pipe #(.EXP_W(HE), .MAN_W(HM), .TAG_W(4), .CNT_W(2)) dut_h (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
      .in_data(in_data_h), .in_tag(in_tag), .out_valid(out_valid_h),
      .out_ready(out_ready), .out_data(out_data_h), .out_tag(out_tag_h),
      .out_class(out_class_h), .cnt_sel(cnt_sel), .cnt_value(cnt_value_h),
      .cnt_clr(cnt_clr), .snan_seen(snan_h));

   fp_classify_pipe #(.EXP_W(SE), .MAN_W(SM), .TAG_W(4), .CNT_W(16)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data_s), .in_tag(in_tag), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_data(out_data_s), .out_tag(out_tag_s),
      .out_class(out_class_s), .cnt_sel(cnt_sel), .cnt_value(cnt_value_s),
      .cnt_clr(cnt_clr), .snan_seen(snan_s));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference classification straight from the field definitions.
   function automatic int ref_class(input logic [63:0] x, input int ew, input int mw);
      logic [63:0] e, f, emax;
      logic        s;
      s    = x[ew+mw];
      e    = (x >> mw) & ((64'd1 << ew) - 64'd1);
      f    = x & ((64'd1 << mw) - 64'd1);
      emax = (64'd1 << ew) - 64'd1;
      if (e == emax) begin
         if (f == 64'd0) return s ? FC_NINF : FC_PINF;
         return f[mw-1] ? FC_QNAN : FC_SNAN;
      end
      if (e == 64'd0) begin
         if (f == 64'd0) return s ? FC_NZERO : FC_PZERO;
         return s ? FC_NSUB : FC_PSUB;
      end
      return s ? FC_NNORM : FC_PNORM;
   endfunction

   typedef struct {
      logic [15:0] dh;
      logic [31:0] ds;
      logic [3:0]  tag;
      int          cyc;
   } item_t;

   item_t q[$];
   int    cnt_mh[10];
   int    cnt_ms[10];
   bit    snan_mh, snan_ms;
   int    cyc = 0;
   bit    chk_lat = 0;
   bit    prev_stall = 0;
   logic [15:0] pd_h;
   logic [31:0] pd_s;
   logic [3:0]  pt;
   logic [9:0]  pc_h, pc_s;

   // Monitor: inputs change only just after posedge, so the values seen at
   // negedge are the ones the next posedge acts on.
   always @(negedge clk) begin
      item_t e;
      int    ch, cs;
      cyc++;
      if (prev_stall) begin
         check("hold_data_h",  64'(out_data_h),  64'(pd_h));
         check("hold_data_s",  64'(out_data_s),  64'(pd_s));
         check("hold_tag",     64'(out_tag_h),   64'(pt));
         check("hold_class_h", 64'(out_class_h), 64'(pc_h));
         check("hold_class_s", 64'(out_class_s), 64'(pc_s));
      end
      check("in_ready_h", 64'(in_ready_h), 64'(!(out_valid_h && !out_ready)));
      check("in_ready_s", 64'(in_ready_s), 64'(!(out_valid_s && !out_ready)));
      check("cnt_value_h", 64'(cnt_value_h), (cnt_sel < 4'd10) ? 64'(cnt_mh[cnt_sel]) : 64'd0);
      check("cnt_value_s", 64'(cnt_value_s), (cnt_sel < 4'd10) ? 64'(cnt_ms[cnt_sel]) : 64'd0);
      check("snan_seen_h", 64'(snan_h), 64'(snan_mh));
      check("snan_seen_s", 64'(snan_s), 64'(snan_ms));

      prev_stall = out_valid_h && !out_ready && !rst;
      pd_h = out_data_h; pd_s = out_data_s; pt = out_tag_h;
      pc_h = out_class_h; pc_s = out_class_s;

      if (rst) begin
         q.delete();
         for (int i = 0; i < 10; i++) begin cnt_mh[i] = 0; cnt_ms[i] = 0; end
         snan_mh = 0; snan_ms = 0;
      end else begin
         if (out_valid_h && out_ready) begin
            if (q.size() == 0) begin
               check("orphan_result", 64'd1, 64'd0);
            end else begin
               e  = q.pop_front();
               ch = ref_class(64'(e.dh), HE, HM);
               cs = ref_class(64'(e.ds), SE, SM);
               check("out_valid_s", 64'(out_valid_s), 64'd1);
               check("out_data_h",  64'(out_data_h),  64'(e.dh));
               check("out_data_s",  64'(out_data_s),  64'(e.ds));
               check("out_tag_h",   64'(out_tag_h),   64'(e.tag));
               check("out_tag_s",   64'(out_tag_s),   64'(e.tag));
               check("out_class_h", 64'(out_class_h), 64'd1 << ch);
               check("out_class_s", 64'(out_class_s), 64'd1 << cs);
               if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
               if (!cnt_clr) begin
                  if (cnt_mh[ch] < HC_MAX) cnt_mh[ch]++;
                  if (cnt_ms[cs] < SC_MAX) cnt_ms[cs]++;
                  if (ch == FC_SNAN) snan_mh = 1;
                  if (cs == FC_SNAN) snan_ms = 1;
               end
            end
         end
         if (cnt_clr) begin
            for (int i = 0; i < 10; i++) begin cnt_mh[i] = 0; cnt_ms[i] = 0; end
            snan_mh = 0; snan_ms = 0;
         end
         if (in_valid && in_ready_h) q.push_back('{in_data_h, in_data_s, in_tag, cyc});
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic send(input logic [15:0] dh, input logic [31:0] ds, input logic [3:0] tg);
      bit done = 0;
      in_valid = 1'b1; in_data_h = dh; in_data_s = ds; in_tag = tg;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready_h) done = 1;
         @(posedge clk); #1;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] v;
      int          k;
      v = 16'($urandom);
      k = $urandom_range(0, 3);
      if (k == 0) v[14:10] = '0;
      else if (k == 1) v[14:10] = '1;
      if ($urandom_range(0, 2) == 0) v[9:0] = '0;
      return v;
   endfunction

   function automatic logic [31:0] rand_single();
      logic [31:0] v;
      int          k;
      v = $urandom;
      k = $urandom_range(0, 3);
      if (k == 0) v[30:23] = '0;
      else if (k == 1) v[30:23] = '1;
      if ($urandom_range(0, 2) == 0) v[22:0] = '0;
      return v;
   endfunction

   logic [15:0] dir_h [8] = '{16'h7C00, 16'hFC00, 16'h8000, 16'h8001,
                              16'h3C00, 16'h7E00, 16'h7D00, 16'hFD01};
   logic [31:0] dir_s [8] = '{32'h7FC00000, 32'h00000001, 32'hFF800000, 32'h3F800000,
                              32'h80000000, 32'h7F800001, 32'h807FFFFF, 32'h00800000};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      in_tag = '0; cnt_sel = '0; in_data_h = '0; in_data_s = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid_h), 64'd0);
      check("rst_in_ready",  64'(in_ready_h),  64'd1);
      check("rst_out_class", 64'(out_class_h), 64'd0);
      check("rst_out_data",  64'(out_data_h),  64'd0);
      @(posedge clk); #1;

      // Directed classes, back-to-back with out_ready high: exact 2-cycle latency.
      chk_lat = 1;
      for (int i = 0; i < 8; i++) send(dir_h[i], dir_s[i], 4'(i));
      idle(4);
      chk_lat = 0;
      @(negedge clk);
      check("snan_after_7D00", 64'(snan_h), 64'd1);
      @(posedge clk); #1;

      // Backpressure: out_ready low for 3 cycles after the first result.
      fork
         begin
            for (int i = 0; i < 4; i++) send(16'h3C00 + 16'(i), 32'h3F800000 + 32'(i), 4'(8 + i));
         end
         begin
            int k = 0;
            do begin @(negedge clk); k++; end while (!out_valid_h && k < 20);
            @(posedge clk); #1 out_ready = 1'b0;
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready_h), 64'd0);
            repeat (2) @(posedge clk);
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      idle(6);

      // Saturation of the 2-bit +zero counter, then clear racing a transfer.
      for (int i = 0; i < 5; i++) send(16'h0000, 32'h00000000, 4'(i));
      idle(4);
      cnt_sel = 4'd4;
      @(negedge clk);
      check("pzero_saturated", 64'(cnt_value_h), 64'd3);
      @(posedge clk); #1;
      send(16'h0000, 32'h00000000, 4'hF);
      @(posedge clk); #1 cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      check("clr_wins_cnt",  64'(cnt_value_h), 64'd0);
      check("clr_wins_snan", 64'(snan_h),      64'd0);
      @(posedge clk); #1;

      // Random traffic with random backpressure, counter reads and clears.
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data_h = rand_half();
         in_data_s = rand_single();
         in_tag    = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cnt_sel   = 4'($urandom);
         cnt_clr   = ($urandom_range(0, 39) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      idle(8);
      check("drained", 64'(q.size()), 64'd0);

      // Reset while stalled with both stages full.
      out_ready = 1'b0;
      send(16'h7D00, 32'h7F800001, 4'h3);
      send(16'h3C00, 32'h3F800000, 4'h4);
      @(negedge clk);
      check("full_stalled", 64'(in_ready_h), 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", 64'(out_valid_h), 64'd0);
      check("mid_rst_in_ready",  64'(in_ready_h),  64'd1);
      check("mid_rst_out_data",  64'(out_data_h),  64'd0);
      check("mid_rst_out_tag",   64'(out_tag_h),   64'd0);
      check("mid_rst_out_class", 64'(out_class_h), 64'd0);
      check("mid_rst_snan",      64'(snan_h),      64'd0);
      for (int i = 0; i < 10; i++) begin
         cnt_sel = 4'(i);
         #1;
         check("mid_rst_cnt_h", 64'(cnt_value_h), 64'd0);
         check("mid_rst_cnt_s", 64'(cnt_value_s), 64'd0);
      end
      idle(3);
      check("no_stale_output", 64'(out_valid_h), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_classify_pipe.md
Name: fp_classify_pipe

Overview:
- Parametrised, pipelined IEEE-754 operand classifier for any binary format: half by default, single and double by parameter.
- Produces a 10-bit one-hot class mask in RISC-V fclass order, with sign resolved.
- Uses valid/ready handshakes on input and output, and carries a user tag through the pipeline.
- Keeps saturating per-class statistics counters and a sticky signalling-NaN flag; sits in front of the FPU issue path and feeds the exception/CSR logic.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, significand (fraction) field width; operand width N = 1+EXP_W+MAN_W.
- TAG_W, 4, width of the pass-through tag.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  N  operand: sign at bit N-1, then exponent, then fraction.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  operand passed through unchanged.
- out_tag  out  TAG_W  tag passed through.
- out_class  out  10  one-hot class mask.
- cnt_sel  in  4  selects a counter (0-9); values 10-15 read as 0.
- cnt_value  out  CNT_W  combinational read of the selected counter.
- cnt_clr  in  1  synchronous clear of all counters and snan_seen.
- snan_seen  out  1  sticky; set when an sNaN result transfers.

Behaviour:
- Field flags:
  - expOnes = all exponent bits 1.
  - expZeros = all exponent bits 0.
  - sigZeros = all fraction bits 0.
  - quiet bit = fraction MSB (bit MAN_W-1).
- Class bits:
  - 0: -inf.
  - 1: -normal.
  - 2: -subnormal.
  - 3: -zero.
  - 4: +zero.
  - 5: +subnormal.
  - 6: +normal.
  - 7: +inf.
  - 8: sNaN (expOnes, !sigZeros, quiet bit 0).
  - 9: qNaN (expOnes, !sigZeros, quiet bit 1).
  - Sign is ignored for NaN.
  - Exactly one bit is set for every valid result.
- Pipeline: two register stages.
  - S1 registers operand, tag and the decoded flags (expOnes, expZeros, sigZeros, quiet bit, sign).
  - S2 registers the class mask, operand and tag; S2 drives all out_* ports.
- Latency: 2 cycles from the input handshake to out_valid when out_ready is held high.
  - Throughput: 1 operand per cycle.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, both stages hold and no bubble is collapsed.
  - While out_valid=1, out_data, out_tag and out_class stay stable until the handshake.
- Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
  - With in_valid=0 and no stall, a bubble (valid=0) enters S1.
- Counters: ten CNT_W counters.
  - On each output transfer, the counter at the set class index increments.
  - Counters saturate at all-ones and never wrap.
- snan_seen: set on an output transfer with class bit 8 set; held until cnt_clr or rst.
- cnt_clr:
  - Clears all counters and snan_seen next cycle; pipeline data is not affected.
  - Clear and increment in the same cycle: clear wins, result 0, the transfer is not counted.
  - snan_seen set and clear in the same cycle: clear wins.
- Reset (rst=1 at a clock edge), including mid-stall with valid data in flight:
  - Both stage valids go to 0 and in-flight data is discarded.
  - out_valid=0, out_class=0, out_data=0, out_tag=0.
  - All counters 0, snan_seen=0, in_ready=1 from the cycle after reset.
  - cnt_value reads 0.

Decomposition:
- Package fp_pkg holds:
  - FCLASS_W=10.
  - Class index constants: FC_NINF, FC_NNORM, FC_NSUB, FC_NZERO, FC_PZERO, FC_PSUB, FC_PNORM, FC_PINF, FC_SNAN, FC_QNAN.
  - Format presets: HALF (5,10), SINGLE (8,23), DOUBLE (11,52).
- Sub-module fp_class_decode: purely combinational field flags -> 10-bit mask, parametrised by EXP_W/MAN_W, instantiated between S1 and S2.

Test Plan:
- Half format, out_ready=1, back-to-back inputs:
  - 0x7C00 -> out_class=0x080.
  - 0xFC00 -> 0x001.
  - 0x8000 -> 0x008.
  - 0x8001 -> 0x004.
  - 0x3C00 -> 0x040.
  - Each result appears exactly 2 cycles after its input and carries its tag.
- NaNs:
  - 0x7E00 -> 0x200; snan_seen stays 0.
  - 0x7D00 -> 0x100; snan_seen=1 the cycle after the transfer.
  - 0xFD01 -> 0x100 (sign ignored).
- Backpressure:
  - Stream 4 operands and hold out_ready=0 for 3 cycles after the first result.
  - in_ready=0 during the stall; out_data stays stable.
  - No loss or duplication; order preserved.
- Counters, CNT_W=2: 5 transfers of 0x0000, cnt_sel=4 -> cnt_value=3 (saturated).
  - Then assert cnt_clr in the same cycle as a +zero transfer -> cnt_value=0, snan_seen=0.
- Reset mid-operation: rst during a stall with both stages full -> next cycle out_valid=0, in_ready=1, all counters 0.
- EXP_W=8, MAN_W=23:
  - 0x7FC00000 -> 0x200.
  - 0x00000001 -> 0x020.
  - 0xFF800000 -> 0x001.
